// File: rtl/exu_div_ctrl.sv
// EX-stage issue/retire controller for the multi-cycle exu_div unit.
// Resolves divide-by-zero and signed overflow locally and absorbs flushes of in-flight divides.
module exu_div_ctrl #(
    parameter int XLEN      = 32,
    parameter int RD_W      = 5,
    parameter bit FAST_PATH = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      req_op_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [RD_W-1:0] req_rd_i,
    input  logic            flush_i,
    output logic            div_start_o,
    output logic [3:0]      div_op_o,
    output logic [XLEN-1:0] div_dividend_o,
    output logic [XLEN-1:0] div_divisor_o,
    input  logic            div_busy_i,
    input  logic            div_valid_i,
    input  logic [XLEN-1:0] div_result_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [RD_W-1:0] wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            busy_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] WB    = 3'd4;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [3:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] wb_data;

    logic            accept;
    logic            by_zero;
    logic            overflow;
    logic            special;
    logic            quotient_op;
    logic            signed_op;
    logic [XLEN-1:0] special_result;

    // Ready is held low during reset so every output reads 0 while rst is high.
    assign req_ready_o = (state == IDLE) & ~flush_i & ~rst;
    assign accept      = req_valid_i & req_ready_o;

    assign quotient_op = req_op_i[0] | req_op_i[1];
    assign signed_op   = req_op_i[0] | req_op_i[2];

    // exu_div never answers a zero divisor, so that case is resolved here regardless of FAST_PATH.
    assign by_zero  = (req_rs2_i == '0);
    assign overflow = (FAST_PATH != 1'b0) & signed_op &
                      (req_rs1_i == INT_MIN) & (req_rs2_i == ALL_ONES);
    assign special  = by_zero | overflow;

    always_comb begin
        special_result = '0;
        if (by_zero) begin
            special_result = quotient_op ? ALL_ONES : req_rs1_i;
        end else if (overflow) begin
            special_result = req_op_i[0] ? INT_MIN : '0;
        end
    end

    // A flush in WAIT cannot abort exu_div, so DRAIN swallows its eventual result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? WB : ISSUE;
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (!div_busy_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (div_valid_i) begin
                    state_next = flush_i ? IDLE : WB;
                end else if (flush_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (div_valid_i) begin
                    state_next = IDLE;
                end
            end
            WB: begin
                if (wb_ready_i || flush_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op      <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            wb_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op  <= req_op_i;
                rs1 <= req_rs1_i;
                rs2 <= req_rs2_i;
                rd  <= req_rd_i;
                if (special) begin
                    wb_data <= special_result;
                end
            end
            if ((state == WAIT) && div_valid_i && !flush_i) begin
                wb_data <= div_result_i;
            end
        end
    end

    assign div_start_o    = (state == ISSUE) & ~div_busy_i & ~flush_i;
    assign div_op_o       = op;
    assign div_dividend_o = rs1;
    assign div_divisor_o  = rs2;
    assign wb_valid_o     = (state == WB);
    assign wb_rd_o        = rd;
    assign wb_data_o      = wb_data;
    assign busy_o         = (state != IDLE);

endmodule
